// File: rtl/ofdm_pkg.sv
// Shared OFDM constants, subcarrier map and frame-controller state encoding.
package ofdm_pkg;
  localparam int NBINS         = 64;
  localparam int GUARD_LO      = 27;
  localparam int GUARD_HI      = 37;
  localparam int NPILOTS       = 4;
  localparam logic [5:0] PILOTS [NPILOTS] = '{6'd7, 6'd21, 6'd43, 6'd57};
  localparam int BYTES_PER_SYM = 12;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DRAIN} state_t;

  // 48 data carriers: everything except DC, the guard band and the four pilots
  function automatic logic is_data_bin(input logic [5:0] bin);
    logic d;
    d = (bin != 6'd0) && !((bin >= 6'(GUARD_LO)) && (bin <= 6'(GUARD_HI)));
    for (int i = 0; i < NPILOTS; i++)
      if (bin == PILOTS[i]) d = 1'b0;
    return d;
  endfunction
endpackage

// File: rtl/demap_frame_ctrl_if.sv
// Bus between the FFT/demapper datapath, the frame controller and the byte sink.
interface demap_frame_ctrl_if;
  logic       frame_start;
  logic [7:0] num_syms;
  logic       fft_en;
  logic       fft_sof;
  logic       demap_en;
  logic [1:0] demap_out;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       frame_done;
  logic       sync_err;
  logic       overflow;

  modport slave (
    input  frame_start, num_syms, fft_en, fft_sof, demap_out, byte_ready,
    output demap_en, byte_out, byte_valid, busy, frame_done, sync_err, overflow
  );
  modport master (
    output frame_start, num_syms, fft_en, fft_sof, demap_out, byte_ready,
    input  demap_en, byte_out, byte_valid, busy, frame_done, sync_err, overflow
  );
endinterface

// File: rtl/byte_fifo4.sv
// Four-entry byte FIFO; a push while full succeeds only when a pop frees a slot.
module byte_fifo4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  logic [7:0] r_mem [4];
  logic [1:0] r_wptr, r_rptr;
  logic [2:0] r_cnt;
  logic       w_push, w_pop;

  assign full   = (r_cnt == 3'd4);
  assign empty  = (r_cnt == 3'd0);
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push && !reset && !flush) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
      r_cnt  <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/demap_frame_ctrl.sv
// OFDM frame controller: tracks bins/symbols, gates the QPSK demapper on data
// carriers and packs four hard-decision pairs per byte into a small FIFO.
module demap_frame_ctrl
  import ofdm_pkg::*;
(
  input logic               clk,
  input logic               reset,
  demap_frame_ctrl_if.slave bus
);
  state_t     r_state, w_state_nxt;
  logic [5:0] r_bin, w_bin;
  logic [7:0] r_sym, r_nsyms;
  logic [5:0] r_pack;
  logic [1:0] r_pcnt;
  logic       r_cap, r_done, r_sync_err, r_overflow;
  logic       w_act, w_demap_en, w_sync, w_sym_end, w_last, w_capture;
  logic       w_push, w_pop, w_full, w_empty;
  logic [7:0] w_din, w_dout;

  assign w_bin      = bus.fft_sof ? 6'd0 : r_bin;
  assign w_act      = ~reset & ~bus.frame_start & bus.fft_en &
                      ((r_state == RUN) | ((r_state == WAIT_SOF) & bus.fft_sof));
  assign w_demap_en = w_act & is_data_bin(w_bin);
  assign w_sync     = w_act & (r_state == RUN) & bus.fft_sof & (r_bin != 6'd0);
  assign w_sym_end  = w_act & (w_bin == 6'(NBINS - 1));
  assign w_last     = w_sym_end & (r_sym == r_nsyms);
  // a resync discards the pair arriving now along with the rest of the partial byte
  assign w_capture  = r_cap & ~w_sync;
  assign w_push     = w_capture & (r_pcnt == 2'd3);
  assign w_din      = {r_pack, bus.demap_out};
  assign w_pop      = bus.byte_ready & ~w_empty;

  always_comb begin
    w_state_nxt = r_state;
    if (bus.frame_start)
      w_state_nxt = (bus.num_syms != 8'd0) ? WAIT_SOF : IDLE;
    else begin
      case (r_state)
        WAIT_SOF: if (w_act)  w_state_nxt = RUN;
        RUN:      if (w_last) w_state_nxt = DRAIN;
        DRAIN:    w_state_nxt = IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin      <= 6'd0;
      r_sym      <= 8'd0;
      r_nsyms    <= 8'd0;
      r_pack     <= 6'd0;
      r_pcnt     <= 2'd0;
      r_cap      <= 1'b0;
      r_done     <= 1'b0;
      r_sync_err <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= bus.frame_start ? (bus.num_syms == 8'd0) : (r_state == DRAIN);
      if (bus.frame_start) begin
        r_nsyms    <= bus.num_syms;
        r_bin      <= 6'd0;
        r_sym      <= 8'd0;
        r_pack     <= 6'd0;
        r_pcnt     <= 2'd0;
        r_cap      <= 1'b0;
        r_sync_err <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        r_cap <= w_demap_en;
        if (w_act) begin
          r_bin <= w_bin + 6'd1;
          if (r_state == WAIT_SOF)     r_sym <= 8'd1;
          else if (w_sym_end && !w_last) r_sym <= r_sym + 8'd1;
        end
        if (w_sync) begin
          r_pcnt     <= 2'd0;
          r_sync_err <= 1'b1;
        end else if (w_capture) begin
          r_pack <= {r_pack[3:0], bus.demap_out};
          r_pcnt <= r_pcnt + 2'd1;
        end
        if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
    end
  end

  byte_fifo4 u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.frame_start),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // every output is forced low while reset is held
  assign bus.demap_en   = w_demap_en;
  assign bus.byte_out   = (reset | w_empty) ? 8'd0 : w_dout;
  assign bus.byte_valid = ~reset & ~w_empty;
  assign bus.busy       = ~reset & (r_state != IDLE);
  assign bus.frame_done = ~reset & r_done;
  assign bus.sync_err   = ~reset & r_sync_err;
  assign bus.overflow   = ~reset & r_overflow;
endmodule

// File: tb/tb_demap_frame_ctrl.sv
// Scoreboard bench: a bin/packer model queues expected bytes as samples are driven.
module tb_demap_frame_ctrl;
  import ofdm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  demap_frame_ctrl_if tif ();

  demap_frame_ctrl dut (.clk(clk), .reset(reset), .bus(tif.slave));

  always #5 clk = ~clk;

  int         n_chk = 0, n_bad = 0, n_bytes = 0, n_done = 0, n_de = 0;
  logic [7:0] last_byte;
  logic [7:0] exp_q [$];

  bit         m_live, m_run, pend_cap;
  logic [5:0] m_bin;
  logic [7:0] m_pack;
  logic [1:0] pend_v;
  int         m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_data(input logic [5:0] b);
    if (b == 6'd0 || (b >= 6'd27 && b <= 6'd37)) return 1'b0;
    if (b == 6'd7 || b == 6'd21 || b == 6'd43 || b == 6'd57) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!reset && tif.byte_valid && tif.byte_ready) begin
      n_bytes++;
      last_byte = tif.byte_out;
      if (exp_q.size() == 0) chk("byte_unexp", 32'(tif.byte_valid), 0);
      else                   chk("byte", 32'(tif.byte_out), 32'(exp_q.pop_front()));
    end
    if (tif.frame_done) n_done++;
  end

  // one sample cycle: demap_out carries the pair for the previous cycle's sample
  task automatic cyc(input bit en, input bit sof, input logic [1:0] v);
    bit sync, act, de;
    logic [5:0] cur;
    @(posedge clk); #1;
    sync = en && sof && m_live && m_run && (m_bin != 6'd0);
    tif.demap_out = pend_v;
    if (pend_cap && !sync) begin
      m_pack = {m_pack[5:0], pend_v};
      if (m_pc == 3) begin exp_q.push_back(m_pack); m_pc = 0; end
      else m_pc++;
    end
    if (sync) m_pc = 0;
    cur = sof ? 6'd0 : m_bin;
    act = en && m_live && (m_run || sof);
    de  = act && tb_data(cur);
    tif.fft_en  = en;
    tif.fft_sof = sof;
    @(negedge clk);
    chk("demap_en", 32'(tif.demap_en), 32'(de));
    if (tif.demap_en) n_de++;
    if (act) begin m_run = 1'b1; m_bin = cur + 6'd1; end
    pend_cap = de;
    pend_v   = v;
  endtask

  task automatic model_clear(input bit live);
    exp_q.delete();
    m_live = live; m_run = 1'b0; m_bin = 6'd0; m_pc = 0; m_pack = 8'd0;
    pend_cap = 1'b0; pend_v = 2'd0;
  endtask

  task automatic fstart(input logic [7:0] n);
    @(posedge clk); #1;
    tif.frame_start = 1'b1; tif.num_syms = n; tif.fft_en = 1'b0; tif.fft_sof = 1'b0;
    model_clear(n != 8'd0);
    @(posedge clk); #1;
    tif.frame_start = 1'b0;
  endtask

  // mode 0: all 11, 1: 00,01,10,11 cycling over data bins, 2: random
  task automatic run_sym(input int first, input int gap, input int mode);
    int dk = 0;
    logic [1:0] v;
    for (int b = first; b < NBINS; b++) begin
      case (mode)
        0:       v = 2'b11;
        1:       v = 2'(dk);
        default: v = 2'($urandom_range(0, 3));
      endcase
      if (tb_data(6'(b))) dk++;
      cyc(1'b1, b == 0, v);
      repeat (gap) cyc(1'b0, 1'b0, 2'd0);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_demap_en"},   32'(tif.demap_en),   0);
    chk({p, "_byte_out"},   32'(tif.byte_out),   0);
    chk({p, "_byte_valid"}, 32'(tif.byte_valid), 0);
    chk({p, "_busy"},       32'(tif.busy),       0);
    chk({p, "_frame_done"}, 32'(tif.frame_done), 0);
    chk({p, "_sync_err"},   32'(tif.sync_err),   0);
    chk({p, "_overflow"},   32'(tif.overflow),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int bb, bd;
    tif.frame_start = 0; tif.num_syms = 0; tif.fft_en = 0; tif.fft_sof = 0;
    tif.demap_out = 0; tif.byte_ready = 0;
    model_clear(1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); chk_zero("rst");
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); chk_zero("post_rst");

    // reset mid-RUN with two bytes queued, colliding with frame_start/fft_en
    fstart(8'd1);
    for (int b = 0; b < 10; b++) cyc(1'b1, b == 0, 2'(b));
    cyc(1'b0, 1'b0, 2'd0); cyc(1'b0, 1'b0, 2'd0);
    chk("pre_rst_valid", 32'(tif.byte_valid), 1);
    chk("pre_rst_busy",  32'(tif.busy), 1);
    @(posedge clk); #1;
    reset = 1'b1; tif.frame_start = 1'b1; tif.num_syms = 8'd3;
    tif.fft_en = 1'b1; tif.fft_sof = 1'b1;
    @(negedge clk); chk_zero("in_rst");
    @(posedge clk); #1;
    reset = 1'b0; tif.frame_start = 1'b0; tif.fft_en = 1'b0; tif.fft_sof = 1'b0;
    model_clear(1'b0);
    @(negedge clk); chk_zero("rst_prio");

    // one symbol of all-ones with a ready sink
    tif.byte_ready = 1'b1;
    fstart(8'd1);
    n_de = 0; bb = n_bytes; bd = n_done;
    for (int b = 0; b < NBINS; b++) begin
      cyc(1'b1, b == 0, 2'b11);
      if (b == 5) chk("lat_early", 32'(tif.byte_valid), 0);
      if (b == 6) chk("lat_min",   32'(tif.byte_valid), 1);
    end
    cyc(1'b0, 1'b0, 2'd0);
    chk("drain_busy", 32'(tif.busy), 1);
    chk("drain_done", 32'(tif.frame_done), 0);
    cyc(1'b0, 1'b0, 2'd0);
    chk("done_pulse", 32'(tif.frame_done), 1);
    chk("done_busy",  32'(tif.busy), 0);
    repeat (3) cyc(1'b0, 1'b0, 2'd0);
    chk("de_count",    32'(n_de), 48);
    chk("ff_bytes",    32'(n_bytes - bb), BYTES_PER_SYM);
    chk("ff_last",     32'(last_byte), 32'h0FF);
    chk("ff_done_cnt", 32'(n_done - bd), 1);
    chk("ff_q_empty",  32'(exp_q.size()), 0);

    // packing order, contiguous then with gaps
    for (int g = 0; g < 2; g++) begin
      fstart(8'd1);
      bb = n_bytes;
      run_sym(0, g, 1);
      repeat (4) cyc(1'b0, 1'b0, 2'd0);
      chk(g == 0 ? "ord_bytes" : "gap_bytes", 32'(n_bytes - bb), BYTES_PER_SYM);
      chk(g == 0 ? "ord_1b" : "gap_1b", 32'(last_byte), 32'h1B);
      chk(g == 0 ? "ord_q" : "gap_q", 32'(exp_q.size()), 0);
    end

    // stalled sink: first four bytes kept, rest dropped
    @(posedge clk); #1; tif.byte_ready = 1'b0;
    fstart(8'd1);
    run_sym(0, 0, 2);
    repeat (3) cyc(1'b0, 1'b0, 2'd0);
    chk("ovf_flag",  32'(tif.overflow), 1);
    chk("ovf_valid", 32'(tif.byte_valid), 1);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    bb = n_bytes;
    @(posedge clk); #1; tif.byte_ready = 1'b1;
    repeat (8) cyc(1'b0, 1'b0, 2'd0);
    chk("ovf_kept",  32'(n_bytes - bb), 4);
    chk("ovf_q",     32'(exp_q.size()), 0);
    chk("ovf_empty", 32'(tif.byte_valid), 0);

    // resync at bin 30 of symbol 1 in a two-symbol frame
    fstart(8'd2);
    chk("ovf_cleared", 32'(tif.overflow), 0);
    bd = n_done;
    run_sym(0, 0, 2);
    for (int b = 0; b < 30; b++) ;
    fstart(8'd2);
    bd = n_done;
    for (int b = 0; b < 30; b++) cyc(1'b1, b == 0, 2'($urandom_range(0, 3)));
    cyc(1'b1, 1'b1, 2'd0);
    bb = n_bytes;
    cyc(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    chk("sync_err", 32'(tif.sync_err), 1);
    run_sym(2, 0, 2);
    run_sym(0, 0, 2);
    repeat (4) cyc(1'b0, 1'b0, 2'd0);
    chk("sync_bytes",  32'(n_bytes - bb), 2 * BYTES_PER_SYM);
    chk("sync_done",   32'(n_done - bd), 1);
    chk("sync_sticky", 32'(tif.sync_err), 1);
    chk("sync_q",      32'(exp_q.size()), 0);

    // zero-symbol frame
    fstart(8'd0);
    @(negedge clk);
    chk("zero_done",   32'(tif.frame_done), 1);
    chk("zero_busy",   32'(tif.busy), 0);
    chk("zero_sync",   32'(tif.sync_err), 0);
    cyc(1'b1, 1'b1, 2'd0);
    chk("zero_done_1", 32'(tif.frame_done), 0);
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 2'd0);
    chk("zero_busy_2", 32'(tif.busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
